// File: rtl/spi_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_shifter
//  Purpose  : SPI data shifter. Loads a transmit byte, drives it out on
//             mosi_o one bit per tx strobe, and assembles a receive byte
//             from one sample per rx strobe. MSB-first or LSB-first order
//             is latched at load time.
//  Ports    : PCLK, PRESET       clock, synchronous active-high reset
//             ss_i               active-low transfer window
//             send_data_i        load strobe (starts a frame)
//             receive_data_i     frame-end strobe (publish or abort)
//             lsbfe_i            1 = LSB first, 0 = MSB first
//             tx_strb_i          advance mosi_o to the next bit
//             rx_strb_i          sample the serial input
//             data_mosi_i[7:0]   transmit byte
//             miso_i             serial input
//             lbk_i              loopback request
//             mosi_o             registered serial output
//             data_miso_o[7:0]   last completed received byte
//             rx_valid_o         one-cycle pulse when data_miso_o updates
//             busy_o             frame in progress (ACTIVE or COMPLETE)
//  Config   : SPI_SHIFTER_LOOPBACK_EN - when defined, lbk_i=1 routes mosi_o
//             back to the receive path instead of miso_i.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_shifter (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       ss_i,
  input  logic       send_data_i,
  input  logic       receive_data_i,
  input  logic       lsbfe_i,
  input  logic       tx_strb_i,
  input  logic       rx_strb_i,
  input  logic [7:0] data_mosi_i,
  input  logic       miso_i,
  input  logic       lbk_i,
  output logic       mosi_o,
  output logic [7:0] data_miso_o,
  output logic       rx_valid_o,
  output logic       busy_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACTIVE   = 2'd1;
  localparam logic [1:0] COMPLETE = 2'd2;

  logic [1:0] state;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic       order;      // latched lsbfe_i for the running frame
  logic [2:0] tx_cnt;
  logic [3:0] rx_cnt;     // bit 3 set means all eight bits received
  logic       serial_in;
  logic [2:0] tx_next;
  logic [2:0] tx_bit_idx;
  logic [2:0] rx_bit_idx;

`ifdef SPI_SHIFTER_LOOPBACK_EN
  assign serial_in = lbk_i ? mosi_o : miso_i;
`else
  logic unused_lbk;
  assign unused_lbk = lbk_i;
  assign serial_in  = miso_i;
`endif

  assign tx_next    = tx_cnt + 3'd1;
  assign tx_bit_idx = order ? tx_next : (3'd7 - tx_next);
  assign rx_bit_idx = order ? rx_cnt[2:0] : (3'd7 - rx_cnt[2:0]);
  assign busy_o     = (state != IDLE);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      mosi_o      <= 1'b0;
      data_miso_o <= 8'h00;
      rx_valid_o  <= 1'b0;
      tx_sr       <= 8'h00;
      rx_sr       <= 8'h00;
      order       <= 1'b0;
      tx_cnt      <= 3'd0;
      rx_cnt      <= 4'd0;
    end else begin
      rx_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (send_data_i) begin
            tx_sr  <= data_mosi_i;
            order  <= lsbfe_i;
            tx_cnt <= 3'd0;
            rx_cnt <= 4'd0;
            rx_sr  <= 8'h00;
            mosi_o <= lsbfe_i ? data_mosi_i[0] : data_mosi_i[7];
            state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (receive_data_i && !rx_cnt[3]) begin
            // Early frame end: drop the partial byte.
            state <= IDLE;
          end else begin
            if (rx_cnt[3]) begin
              state <= COMPLETE;
            end
            if (!ss_i) begin
              // The last bit is held; tx_cnt never wraps within a frame.
              if (tx_strb_i && (tx_cnt != 3'd7)) begin
                tx_cnt <= tx_next;
                mosi_o <= tx_sr[tx_bit_idx];
              end
              if (rx_strb_i && !rx_cnt[3]) begin
                rx_sr[rx_bit_idx] <= serial_in;
                rx_cnt            <= rx_cnt + 4'd1;
              end
            end
          end
        end
        COMPLETE: begin
          if (receive_data_i) begin
            data_miso_o <= rx_sr;
            rx_valid_o  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_shifter
//  Purpose  : Self-checking bench for spi_shifter. A frame-level model
//             (bit lists, received-bit list) predicts every output and is
//             compared on each falling edge; directed scenarios add literal
//             expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_shifter;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       ss_i = 1'b1;
  logic       send_data_i = 1'b0;
  logic       receive_data_i = 1'b0;
  logic       lsbfe_i = 1'b0;
  logic       tx_strb_i = 1'b0;
  logic       rx_strb_i = 1'b0;
  logic [7:0] data_mosi_i = 8'h00;
  logic       miso_i = 1'b0;
  logic       lbk_i = 1'b0;
  logic       mosi_o;
  logic [7:0] data_miso_o;
  logic       rx_valid_o;
  logic       busy_o;

`ifdef SPI_SHIFTER_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  spi_shifter dut (
    .PCLK(PCLK), .PRESET(PRESET), .ss_i(ss_i), .send_data_i(send_data_i),
    .receive_data_i(receive_data_i), .lsbfe_i(lsbfe_i), .tx_strb_i(tx_strb_i),
    .rx_strb_i(rx_strb_i), .data_mosi_i(data_mosi_i), .miso_i(miso_i),
    .lbk_i(lbk_i), .mosi_o(mosi_o), .data_miso_o(data_miso_o),
    .rx_valid_o(rx_valid_o), .busy_o(busy_o)
  );

  always #5 PCLK = ~PCLK;

  int n_pass = 0;
  int n_total = 0;
  int n_valid = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- frame-level model ----------------
  int       m_phase = 0;           // 0 idle, 1 shifting, 2 waiting for frame end
  bit       m_tx[8];               // transmit bits in wire order
  int       m_txi = 0;             // index of the bit currently on mosi
  bit       m_rx[8];               // received bits in arrival order
  int       m_rxn = 0;
  bit       m_lsb = 1'b0;
  bit       m_mosi = 1'b0;
  bit [7:0] m_data = 8'h00;
  bit       m_valid = 1'b0;

  initial forever begin
    @(posedge PCLK);
    if (PRESET) begin
      m_phase = 0; m_mosi = 0; m_data = 8'h00; m_valid = 0; m_txi = 0; m_rxn = 0;
    end else begin
      m_valid = 0;
      if (m_phase == 0) begin
        if (send_data_i) begin
          m_lsb = lsbfe_i;
          for (int k = 0; k < 8; k++) m_tx[k] = lsbfe_i ? data_mosi_i[k] : data_mosi_i[7-k];
          m_txi = 0; m_rxn = 0; m_mosi = m_tx[0]; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (receive_data_i && m_rxn < 8) m_phase = 0;
        else begin
          bit sin;
          sin = (LB && lbk_i) ? m_mosi : miso_i;
          if (m_rxn == 8) m_phase = 2;
          if (!ss_i) begin
            if (tx_strb_i && m_txi < 7) begin m_txi++; m_mosi = m_tx[m_txi]; end
            if (rx_strb_i && m_rxn < 8) begin m_rx[m_rxn] = sin; m_rxn++; end
          end
        end
      end else begin
        if (receive_data_i) begin
          for (int k = 0; k < 8; k++) m_data[m_lsb ? k : 7-k] = m_rx[k];
          m_valid = 1; m_phase = 0;
        end
      end
    end
  end

  always @(negedge PCLK) begin
    if (chk_en) begin
      chk("mosi_o", {7'd0, mosi_o}, {7'd0, m_mosi});
      chk("data_miso_o", data_miso_o, m_data);
      chk("rx_valid_o", {7'd0, rx_valid_o}, {7'd0, m_valid});
      chk("busy_o", {7'd0, busy_o}, {7'd0, (m_phase != 0)});
      if (rx_valid_o === 1'b1) n_valid++;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] seq;

  task automatic tick();
    @(posedge PCLK); #1;
  endtask

  task automatic load(input logic [7:0] d, input logic l);
    ss_i = 1'b0; data_mosi_i = d; lsbfe_i = l; send_data_i = 1'b1;
    tick();
    send_data_i = 1'b0;
    seq[7] = mosi_o;
  endtask

  // miso bits given in time order (first bit in p[7]); mosi captured in time order into seq[7:0]
  task automatic strobes(input int n, input logic [7:0] p, input logic resend);
    for (int i = 0; i < n; i++) begin
      tx_strb_i = 1'b1; rx_strb_i = 1'b1; miso_i = p[7-i];
      send_data_i = resend; data_mosi_i = resend ? 8'hFF : data_mosi_i;
      tick();
      tx_strb_i = 1'b0; rx_strb_i = 1'b0; send_data_i = 1'b0;
      if (i < 7) seq[6-i] = mosi_o;
    end
  endtask

  task automatic finish_frame();
    tick();
    receive_data_i = 1'b1;
    tick();
    receive_data_i = 1'b0;
    tick();
  endtask

  initial begin
    tick(); tick();
    chk_en = 1'b1;
    chk("reset mosi", {7'd0, mosi_o}, 8'h00);
    chk("reset data", data_miso_o, 8'h00);
    chk("reset busy", {7'd0, busy_o}, 8'h00);
    PRESET = 1'b0;
    tick();

    // MSB first, A5 out, C3 in
    n_valid = 0;
    load(8'hA5, 1'b0);
    strobes(8, 8'b1100_0011, 1'b0);
    chk("msb mosi seq", seq, 8'b1010_0101);
    finish_frame();
    chk("msb data", data_miso_o, 8'hC3);
    chk("msb pulses", n_valid[7:0], 8'd1);

    // LSB first, same stimulus
    n_valid = 0;
    load(8'hA5, 1'b1);
    strobes(8, 8'b1100_0011, 1'b0);
    chk("lsb mosi seq", seq, 8'b1010_0101);
    finish_frame();
    chk("lsb data", data_miso_o, 8'hC3);
    chk("lsb pulses", n_valid[7:0], 8'd1);

    // abort after 4 bits
    n_valid = 0;
    load(8'h3C, 1'b0);
    strobes(4, 8'b1111_0000, 1'b0);
    receive_data_i = 1'b1; tick(); receive_data_i = 1'b0; tick();
    chk("abort busy", {7'd0, busy_o}, 8'h00);
    chk("abort data", data_miso_o, 8'hC3);
    chk("abort pulses", n_valid[7:0], 8'd0);

    // reload attempt mid-frame is ignored
    load(8'h00, 1'b0);
    strobes(8, 8'b0101_0101, 1'b1);
    chk("noreload seq", seq, 8'h00);
    finish_frame();
    chk("noreload data", data_miso_o, 8'h55);

    // reset mid-frame, then a clean frame with an ignored ss_i=1 strobe first
    load(8'hF0, 1'b0);
    strobes(3, 8'b1110_0000, 1'b0);
    PRESET = 1'b1; tick(); PRESET = 1'b0;
    chk("midrst mosi", {7'd0, mosi_o}, 8'h00);
    chk("midrst data", data_miso_o, 8'h00);
    chk("midrst busy", {7'd0, busy_o}, 8'h00);
    chk("midrst valid", {7'd0, rx_valid_o}, 8'h00);
    load(8'h81, 1'b0);
    ss_i = 1'b1; tx_strb_i = 1'b1; rx_strb_i = 1'b1; miso_i = 1'b0; tick();
    tx_strb_i = 1'b0; rx_strb_i = 1'b0; ss_i = 1'b0;
    strobes(8, 8'b1000_0001, 1'b0);
    chk("after rst seq", seq, 8'h81);
    finish_frame();
    chk("after rst data", data_miso_o, 8'h81);

`ifdef SPI_SHIFTER_LOOPBACK_EN
    lbk_i = 1'b1;
    load(8'h5A, 1'b0);
    strobes(8, 8'h00, 1'b0);
    finish_frame();
    chk("loopback data", data_miso_o, 8'h5A);
    lbk_i = 1'b0;
`endif

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
